// File: rtl/qnigma_poly1305_blk_fmt.sv
// Poly1305 message block formatter.
// Packs a little-endian byte stream into 17-byte Poly1305 blocks
// (up to 16 message bytes, 0x01 marker, zero fill), double-buffered
// between a fill register and an output register.

package qnigma_poly1305_pkg;
  localparam int unsigned BLOCK_BYTES = 17;
  typedef logic [BLOCK_BYTES*8-1:0] poly_blk_t;
endpackage

module qnigma_poly1305_blk_fmt
  import qnigma_poly1305_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_dat,
  input  logic       in_val,
  input  logic       in_lst,
  output logic       in_rdy,
  output poly_blk_t  blk_dat,
  output logic [4:0] blk_len,
  output logic       blk_lst,
  output logic       blk_val,
  input  logic       blk_rdy
);

  // Fill side
  logic [15:0][7:0] r_fil;
  logic [3:0]       r_cnt;
  logic             r_pend;
  logic [4:0]       r_pn;
  logic             r_plst;

  // Output side
  poly_blk_t        r_blk;
  logic [4:0]       r_len;
  logic             r_lst;
  logic             r_val;

  logic             w_out_free;
  logic             w_acc;
  logic             w_cmp;
  logic             w_load;
  logic [4:0]       w_n;
  logic [15:0][7:0] w_fil_new;
  logic [15:0][7:0] w_src_fil;
  logic [4:0]       w_src_n;
  logic [31:0]      w_src_n32;
  poly_blk_t        w_ext;
  poly_blk_t        w_form;

  assign w_out_free = !r_val || blk_rdy;
  assign w_acc      = in_val && !r_pend;
  assign w_cmp      = w_acc && (in_lst || (r_cnt == 4'd15));
  assign w_n        = {1'b0, r_cnt} + 5'd1;

  // A parked block has priority for the output; otherwise a completing
  // input byte may load the output register in the same cycle.
  assign w_load     = r_pend ? w_out_free : (w_cmp && w_out_free);

  assign w_src_fil  = r_pend ? r_fil : w_fil_new;
  assign w_src_n    = r_pend ? r_pn  : w_n;
  assign w_src_n32  = {27'd0, w_src_n};
  assign w_ext      = {8'h00, w_src_fil};

  // Fill register image including the byte being accepted this cycle
  always_comb begin
    w_fil_new        = r_fil;
    w_fil_new[r_cnt] = in_dat;
  end

  // Block formation: message bytes, 0x01 marker at index n, zeros above
  always_comb begin
    w_form = '0;
    for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
      if (i < w_src_n32) begin
        w_form[8*i +: 8] = w_ext[8*i +: 8];
      end else if (i == w_src_n32) begin
        w_form[8*i +: 8] = 8'h01;
      end else begin
        w_form[8*i +: 8] = 8'h00;
      end
    end
  end

  // Fill/pending/output register update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fil  <= '0;
      r_cnt  <= '0;
      r_pend <= 1'b0;
      r_pn   <= '0;
      r_plst <= 1'b0;
      r_blk  <= '0;
      r_len  <= '0;
      r_lst  <= 1'b0;
      r_val  <= 1'b0;
    end else if (w_load) begin
      r_blk  <= w_form;
      r_len  <= w_src_n;
      r_lst  <= r_pend ? r_plst : in_lst;
      r_val  <= 1'b1;
      r_fil  <= '0;
      r_cnt  <= '0;
      r_pend <= 1'b0;
      r_pn   <= '0;
      r_plst <= 1'b0;
    end else begin
      if (blk_rdy) begin
        r_val <= 1'b0;
      end
      if (w_cmp) begin
        r_fil  <= w_fil_new;
        r_pend <= 1'b1;
        r_pn   <= w_n;
        r_plst <= in_lst;
      end else if (w_acc) begin
        r_fil <= w_fil_new;
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign in_rdy  = !r_pend;
  assign blk_dat = r_blk;
  assign blk_len = r_len;
  assign blk_lst = r_lst;
  assign blk_val = r_val;

endmodule

// File: tb/tb_qnigma_poly1305_blk_fmt.sv
// Self-checking bench for qnigma_poly1305_blk_fmt: directed vector table,
// backpressure, random stalls and reset sequences, with a reference
// formatter feeding an expected-block queue.

module tb_qnigma_poly1305_blk_fmt;
  import qnigma_poly1305_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_dat = '0;
  logic       in_val = 1'b0;
  logic       in_lst = 1'b0;
  logic       in_rdy;
  poly_blk_t  blk_dat;
  logic [4:0] blk_len;
  logic       blk_lst;
  logic       blk_val;
  logic       blk_rdy = 1'b0;

  qnigma_poly1305_blk_fmt dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_dat  (in_dat),
    .in_val  (in_val),
    .in_lst  (in_lst),
    .in_rdy  (in_rdy),
    .blk_dat (blk_dat),
    .blk_len (blk_len),
    .blk_lst (blk_lst),
    .blk_val (blk_val),
    .blk_rdy (blk_rdy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    poly_blk_t  dat;
    logic [4:0] len;
    logic       lst;
  } blk_t;

  typedef struct {
    int         len;
    logic [7:0] start;
    logic [7:0] step;
    int         exp_blocks;
    int         exp_last_len;
  } vec_t;

  blk_t       exp_q[$];
  blk_t       e;
  blk_t       h;
  bit         hold_v;
  int         checks;
  int         errors;
  int         blk_cnt;
  int         acc_cnt;
  int         rdy_drop;
  logic [4:0] last_len;
  logic       last_lst;
  bit         tp_mon;
  bit         rdy_rand;
  bit         rdy_force;
  vec_t       vecs[6];
  logic [7:0] msg[$];
  int         bc0;
  int         acc0;

  function automatic void chk_int(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic void chk_blk(input string name, input poly_blk_t act, input poly_blk_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // Reference formatter: split into 16-byte chunks, add marker and zero fill
  function automatic void push_exp(input logic [7:0] m[$]);
    int   b;
    int   n;
    blk_t x;
    b = 0;
    while (b < m.size()) begin
      n = (m.size() - b > 16) ? 16 : m.size() - b;
      x.dat = '0;
      for (int i = 0; i < n; i++) x.dat[8*i +: 8] = m[b+i];
      x.dat[8*n +: 8] = 8'h01;
      x.len = 5'(n);
      x.lst = ((b + n) == m.size());
      exp_q.push_back(x);
      b += n;
    end
  endfunction

  task automatic send_msg(input logic [7:0] m[$], input bit push, input bit last, input bit gaps);
    if (push) push_exp(m);
    for (int i = 0; i < m.size(); i++) begin
      int wait_cyc = 0;
      bit done = 1'b0;
      while (!done) begin
        if (gaps && ($urandom_range(0, 1) == 0)) begin
          in_val = 1'b0;
        end else begin
          in_val = 1'b1;
          in_dat = m[i];
          in_lst = last && (i == m.size() - 1);
        end
        @(negedge clk);
        done = in_val && in_rdy;
        @(posedge clk);
        #1;
        wait_cyc++;
        if (!done && wait_cyc > 2000) begin
          checks++;
          errors++;
          $display("FAIL in_timeout byte=%0d actual in_rdy=%0b required=1", i, in_rdy);
          in_val = 1'b0;
          in_lst = 1'b0;
          return;
        end
      end
    end
    in_val = 1'b0;
    in_lst = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || blk_val) && c < 4000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk_int("drain_done", int'(exp_q.size() == 0 && !blk_val), 1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{len: 16, start: 8'h00, step: 8'h01, exp_blocks: 1, exp_last_len: 16};
    vecs[1] = '{len: 3,  start: 8'hAA, step: 8'h11, exp_blocks: 1, exp_last_len: 3};
    vecs[2] = '{len: 34, start: 8'h00, step: 8'h01, exp_blocks: 3, exp_last_len: 2};
    vecs[3] = '{len: 1,  start: 8'h5A, step: 8'h00, exp_blocks: 1, exp_last_len: 1};
    vecs[4] = '{len: 17, start: 8'h80, step: 8'h01, exp_blocks: 2, exp_last_len: 1};
    vecs[5] = '{len: 32, start: 8'hF0, step: 8'h03, exp_blocks: 2, exp_last_len: 16};

    fork
      // Output monitor and scoreboard
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          hold_v = 1'b0;
        end else begin
          if (hold_v) begin
            checks++;
            if (!blk_val || blk_dat !== h.dat || blk_len !== h.len || blk_lst !== h.lst) begin
              errors++;
              $display("FAIL hold_stable actual val=%0b len=%0d lst=%0b required val=1 len=%0d lst=%0b",
                       blk_val, blk_len, blk_lst, h.len, h.lst);
            end
          end
          hold_v = blk_val && !blk_rdy;
          h.dat  = blk_dat;
          h.len  = blk_len;
          h.lst  = blk_lst;
          if (in_val && in_rdy) acc_cnt++;
          if (tp_mon && in_val && !in_rdy) rdy_drop++;
          if (blk_val && blk_rdy) begin
            blk_cnt++;
            last_len = blk_len;
            last_lst = blk_lst;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_block actual len=%0d required none", blk_len);
            end else begin
              e = exp_q.pop_front();
              chk_blk("blk_dat", blk_dat, e.dat);
              chk_int("blk_len", int'(blk_len), int'(e.len));
              chk_int("blk_lst", int'(blk_lst), int'(e.lst));
            end
          end
        end
      end
      // Consumer ready driver
      forever begin
        @(posedge clk);
        #1;
        blk_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
      end
    join_none

    // Reset state
    rdy_force = 1'b1;
    rst_n = 1'b0;
    cycles(3);
    chk_int("rst_blk_val", int'(blk_val), 0);
    chk_int("rst_blk_lst", int'(blk_lst), 0);
    chk_int("rst_blk_len", int'(blk_len), 0);
    chk_blk("rst_blk_dat", blk_dat, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_int("rst_in_rdy", int'(in_rdy), 1);
    cycles(1);

    // Full block: latency and exact contents
    tp_mon = 1'b1;
    msg.delete();
    for (int i = 0; i < 16; i++) msg.push_back(i[7:0]);
    chk_int("pre_blk_val", int'(blk_val), 0);
    send_msg(msg, 1'b1, 1'b1, 1'b0);
    chk_int("lat_blk_val", int'(blk_val), 1);
    chk_blk("full_dat", blk_dat, {8'h01, 128'h0F0E0D0C0B0A09080706050403020100});
    chk_int("full_len", int'(blk_len), 16);
    chk_int("full_lst", int'(blk_lst), 1);
    drain();

    // Directed vector table
    for (int v = 0; v < 6; v++) begin
      msg.delete();
      for (int i = 0; i < vecs[v].len; i++) msg.push_back(vecs[v].start + vecs[v].step * i[7:0]);
      bc0 = blk_cnt;
      send_msg(msg, 1'b1, 1'b1, 1'b0);
      drain();
      chk_int($sformatf("vec%0d_blocks", v), blk_cnt - bc0, vecs[v].exp_blocks);
      chk_int($sformatf("vec%0d_last_len", v), int'(last_len), vecs[v].exp_last_len);
      chk_int($sformatf("vec%0d_last_lst", v), int'(last_lst), 1);
    end
    chk_int("throughput_no_stall", rdy_drop, 0);
    tp_mon = 1'b0;

    // Backpressure: 48 bytes, consumer stalled 60 cycles
    rdy_force = 1'b0;
    cycles(2);
    acc0 = acc_cnt;
    bc0  = blk_cnt;
    msg.delete();
    for (int i = 0; i < 48; i++) msg.push_back(i[7:0]);
    fork
      send_msg(msg, 1'b1, 1'b1, 1'b0);
      begin
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk_int("bp_accepted", acc_cnt - acc0, 32);
        chk_int("bp_in_rdy", int'(in_rdy), 0);
        chk_int("bp_no_output", blk_cnt - bc0, 0);
        rdy_force = 1'b1;
      end
    join
    drain();
    chk_int("bp_blocks", blk_cnt - bc0, 3);
    chk_int("bp_accepted_all", acc_cnt - acc0, 48);

    // Random stalls on both sides
    rdy_rand = 1'b1;
    for (int k = 0; k < 200; k++) begin
      int len;
      len = int'($urandom_range(1, 100));
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      send_msg(msg, 1'b1, 1'b1, 1'b1);
    end
    drain();
    rdy_rand = 1'b0;
    rdy_force = 1'b1;
    cycles(2);

    // Reset after 7 bytes of a message
    msg.delete();
    for (int i = 0; i < 7; i++) msg.push_back(8'hC0 + i[7:0]);
    send_msg(msg, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_int("rstA_blk_val", int'(blk_val), 0);
    chk_blk("rstA_blk_dat", blk_dat, '0);
    cycles(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk_int("rstA_in_rdy", int'(in_rdy), 1);
    cycles(1);

    // Reset with one block in the output and one pending
    rdy_force = 1'b0;
    cycles(2);
    msg.delete();
    for (int i = 0; i < 32; i++) msg.push_back(8'h40 + i[7:0]);
    send_msg(msg, 1'b0, 1'b0, 1'b0);
    chk_int("rstB_pend_in_rdy", int'(in_rdy), 0);
    chk_int("rstB_pend_blk_val", int'(blk_val), 1);
    rst_n = 1'b0;
    #1;
    chk_int("rstB_blk_val", int'(blk_val), 0);
    chk_int("rstB_blk_len", int'(blk_len), 0);
    chk_int("rstB_blk_lst", int'(blk_lst), 0);
    chk_blk("rstB_blk_dat", blk_dat, '0);
    rdy_force = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk_int("rstB_in_rdy", int'(in_rdy), 1);
    bc0 = blk_cnt;
    cycles(5);
    chk_int("rstB_quiet_val", int'(blk_val), 0);
    chk_int("rstB_quiet_cnt", blk_cnt - bc0, 0);
    msg.delete();
    for (int i = 0; i < 5; i++) msg.push_back(8'h11 * i[7:0] + 8'h01);
    send_msg(msg, 1'b1, 1'b1, 1'b0);
    drain();
    chk_int("rstB_new_blocks", blk_cnt - bc0, 1);
    chk_int("rstB_new_len", int'(last_len), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
